// File: rtl/shape_sequencer.sv
// shape_sequencer: command front end for the line rasterizer.
// Queues shape commands (line / triangle / rectangle / clear) in a small FIFO
// and issues one rasterizer segment at a time over the start/line_done handshake.
// Optional build macro: SEQ_TIMEOUT_EN adds a per-segment watchdog that sets
// timeout_err and abandons the rest of the shape.
module shape_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_ax,
    input  logic [7:0] cmd_ay,
    input  logic [7:0] cmd_bx,
    input  logic [7:0] cmd_by,
    input  logic [7:0] cmd_cx,
    input  logic [7:0] cmd_cy,
    output logic [7:0] x0,
    output logic [7:0] y0,
    output logic [7:0] x1,
    output logic [7:0] y1,
    output logic       start,
    output logic       reset_buff,
    input  logic       line_done,
    output logic       busy,
    output logic       shape_done,
    output logic [1:0] edge_idx,
    output logic       timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] T_LINE  = 2'b00;
    localparam logic [1:0] T_TRI   = 2'b01;
    localparam logic [1:0] T_RECT  = 2'b10;
    localparam logic [1:0] T_CLEAR = 2'b11;

    // Elaboration-time parameter sanity checks.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("shape_sequencer: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("shape_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t state, next_state;

    // ------------------------------------------------------------------
    // Command FIFO: {type, ax, ay, bx, by, cx, cy} = 50 bits per entry
    // ------------------------------------------------------------------
    logic [49:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [49:0]   head;

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr];

    // FIFO storage write; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_type, cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Segment geometry
    // ------------------------------------------------------------------
    // Endpoints {x0, y0, x1, y1} of segment idx of a stored command.
    function automatic logic [31:0] seg_coords(input logic [49:0] c, input logic [1:0] idx);
        logic [1:0] t;
        logic [7:0] ax, ay, bx, by, cx, cy;
        {t, ax, ay, bx, by, cx, cy} = c;
        seg_coords = {ax, ay, bx, by};
        case (t)
            T_TRI: begin
                case (idx)
                    2'd1:    seg_coords = {bx, by, cx, cy};
                    2'd2:    seg_coords = {cx, cy, ax, ay};
                    default: seg_coords = {ax, ay, bx, by};
                endcase
            end
            T_RECT: begin
                case (idx)
                    2'd0:    seg_coords = {ax, ay, bx, ay};
                    2'd1:    seg_coords = {bx, ay, bx, by};
                    2'd2:    seg_coords = {bx, by, ax, by};
                    default: seg_coords = {ax, by, ax, ay};
                endcase
            end
            default: seg_coords = {ax, ay, bx, by};
        endcase
    endfunction

    // Index of the final segment for each shape type.
    function automatic logic [1:0] last_idx(input logic [1:0] t);
        case (t)
            T_TRI:   last_idx = 2'd2;
            T_RECT:  last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    endfunction

    logic [49:0] cmd_q;
    logic [31:0] seg_q;
    logic [1:0]  edge_idx_q;
    logic        is_last;
    logic        timeout_hit;

    assign is_last  = (edge_idx_q == last_idx(cmd_q[49:48]));
    assign {x0, y0, x1, y1} = seg_q;
    assign edge_idx = edge_idx_q;

    // ------------------------------------------------------------------
    // Optional per-segment watchdog
    // ------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // The last WAIT cycle before the limit; line_done in that cycle takes priority.
    assign timeout_hit = (state == S_WAIT) && !line_done &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;

    // WAIT-cycle counter, restarted whenever a segment is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    // State register plus latched command, segment index and endpoints.
    // Endpoints are only loaded on the transition into ISSUE so they stay
    // stable for the whole WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            edge_idx_q <= '0;
            seg_q      <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                cmd_q      <= head;
                edge_idx_q <= '0;
                if (head[49:48] != T_CLEAR) begin
                    seg_q <= seg_coords(head, 2'd0);
                end
            end else if (state == S_NEXT && !is_last) begin
                edge_idx_q <= edge_idx_q + 2'd1;
                seg_q      <= seg_coords(cmd_q, edge_idx_q + 2'd1);
            end
        end
    end

    // Next-state logic and per-state output pulses.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        start      = 1'b0;
        reset_buff = 1'b0;
        shape_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = (head[49:48] == T_CLEAR) ? S_CLEAR : S_ISSUE;
                end
            end
            S_ISSUE: begin
                start      = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (line_done) begin
                    next_state = S_NEXT;
                end else if (timeout_hit) begin
                    next_state = S_DONE;
                end
            end
            S_NEXT: begin
                next_state = is_last ? S_DONE : S_ISSUE;
            end
            S_CLEAR: begin
                reset_buff = 1'b1;
                next_state = S_DONE;
            end
            S_DONE: begin
                shape_done = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // T_LINE is the default decode above; referenced here for readability only.
    logic unused_line_tag;
    assign unused_line_tag = (T_LINE == 2'b00);

endmodule
